// File: rtl/mips_alu_seq_exec_if.sv
// Request/response bundle between register-read and the sequential ALU execute stage.
// The master drives operands and out_ready; the slave returns in_ready and the result.
interface mips_alu_seq_exec_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned SH_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       ALU_Op;
   logic [5:0]       funct;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             ovf;
   logic             err;

   modport master (
      output in_valid, ALU_Op, funct, shamt, A, B, out_ready,
      input  in_ready, out_valid, result, ovf, err
   );

   modport slave (
      input  in_valid, ALU_Op, funct, shamt, A, B, out_ready,
      output in_ready, out_valid, result, ovf, err
   );
endinterface

// File: rtl/mips_alu_seq_exec.sv
// Sequential MIPS ALU execute stage: single-cycle add/sub, iterative shifter,
// illegal-encoding and signed-overflow flags, valid/ready on both sides.
module mips_alu_seq_exec #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mips_alu_seq_exec_if.slave    io_bus
);
   localparam int unsigned SH_W = $clog2(WIDTH);
   localparam int unsigned K_W  = SH_W + 1;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100;
   localparam logic [5:0] F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WIDTH-1:0]  r_result;
   logic [WIDTH-1:0]  w_result;
   logic              r_ovf;
   logic              w_ovf;
   logic              r_err;
   logic              w_err;
   logic              r_out_valid;
   logic [SH_W-1:0]   r_nrem;
   logic [SH_W-1:0]   w_nrem;
   logic              r_left;
   logic              w_left;
   logic              r_arith;
   logic              w_arith;

   logic              w_accept;
   logic              w_is_sub;
   logic              w_is_shift;
   logic              w_illegal;
   logic              w_dec_left;
   logic              w_dec_arith;
   logic              w_dec_var;
   logic [WIDTH-1:0]  w_bop;
   logic [WIDTH-1:0]  w_sum;
   logic              w_sum_ovf;
   logic [SH_W-1:0]   w_amt;
   logic [K_W-1:0]    w_k;
   logic signed [WIDTH-1:0] w_sra;
   logic [WIDTH-1:0]  w_shifted;
   logic [SH_W-1:0]   w_nrem_dec;

   assign io_bus.in_ready  = (r_state == S_IDLE) & ~rst;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.result    = r_result;
   assign io_bus.ovf       = r_ovf;
   assign io_bus.err       = r_err;
   assign w_accept         = io_bus.in_valid & io_bus.in_ready;

   // ALU_Op / funct decode
   always_comb begin
      w_is_sub    = 1'b0;
      w_is_shift  = 1'b0;
      w_illegal   = 1'b0;
      w_dec_left  = 1'b0;
      w_dec_arith = 1'b0;
      w_dec_var   = 1'b0;
      case (io_bus.ALU_Op)
         2'b00: w_is_sub = 1'b0;
         2'b01: w_is_sub = 1'b1;
         2'b10: begin
            case (io_bus.funct)
               F_ADD:  w_is_sub = 1'b0;
               F_SUB:  w_is_sub = 1'b1;
               F_SLL:  begin w_is_shift = 1'b1; w_dec_left = 1'b1; end
               F_SRL:  w_is_shift = 1'b1;
               F_SRA:  begin w_is_shift = 1'b1; w_dec_arith = 1'b1; end
               F_SLLV: begin w_is_shift = 1'b1; w_dec_left = 1'b1; w_dec_var = 1'b1; end
               F_SRLV: begin w_is_shift = 1'b1; w_dec_var = 1'b1; end
               F_SRAV: begin w_is_shift = 1'b1; w_dec_arith = 1'b1; w_dec_var = 1'b1; end
               default: w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // Subtraction as A + ~B + 1; overflow when operand signs agree but the sum's differs
   assign w_bop     = w_is_sub ? ~io_bus.B : io_bus.B;
   assign w_sum     = io_bus.A + w_bop + WIDTH'(w_is_sub);
   assign w_sum_ovf = (io_bus.A[WIDTH-1] == w_bop[WIDTH-1]) & (w_sum[WIDTH-1] != io_bus.A[WIDTH-1]);
   assign w_amt     = w_dec_var ? io_bus.B[SH_W-1:0] : io_bus.shamt;

   // One shifter iteration of min(n_rem, SHIFT_STEP) positions
   assign w_k        = (K_W'(r_nrem) < K_W'(SHIFT_STEP)) ? K_W'(r_nrem) : K_W'(SHIFT_STEP);
   assign w_sra      = $signed(r_result) >>> w_k;
   assign w_shifted  = r_left  ? (r_result << w_k) :
                       r_arith ? WIDTH'(w_sra)     :
                                 (r_result >> w_k);
   assign w_nrem_dec = r_nrem - SH_W'(w_k);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_result = r_result;
      w_ovf    = r_ovf;
      w_err    = r_err;
      w_nrem   = r_nrem;
      w_left   = r_left;
      w_arith  = r_arith;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_ovf  = 1'b0;
               w_err  = 1'b0;
               w_next = S_DONE;
               if (w_illegal) begin
                  w_result = '0;
                  w_err    = 1'b1;
               end else if (w_is_shift) begin
                  w_result = io_bus.A;
                  w_nrem   = w_amt;
                  w_left   = w_dec_left;
                  w_arith  = w_dec_arith;
                  if (w_amt != '0) w_next = S_SHIFT;
               end else begin
                  w_result = w_sum;
                  w_ovf    = w_sum_ovf;
               end
            end
         end
         S_SHIFT: begin
            w_result = w_shifted;
            w_nrem   = w_nrem_dec;
            if (w_nrem_dec == '0) w_next = S_DONE;
         end
         S_DONE: begin
            if (io_bus.out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath registers; out_valid tracks DONE so it is glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_nrem      <= '0;
         r_left      <= 1'b0;
         r_arith     <= 1'b0;
      end else begin
         r_result    <= w_result;
         r_ovf       <= w_ovf;
         r_err       <= w_err;
         r_out_valid <= (w_next == S_DONE);
         r_nrem      <= w_nrem;
         r_left      <= w_left;
         r_arith     <= w_arith;
      end
   end
endmodule

// File: tb/tb_mips_alu_seq_exec.sv
// Randomized bench for mips_alu_seq_exec: SHIFT_STEP=1 and SHIFT_STEP=2 instances
// run in lockstep against an arithmetic reference model.
module tb_mips_alu_seq_exec;
   localparam int unsigned W    = 32;
   localparam int unsigned SH_W = 5;
   localparam longint MAX_S = 64'sh7FFFFFFF;
   localparam longint MIN_S = -64'sh80000000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_alu_seq_exec_if #(.WIDTH(W)) bus1 ();
   mips_alu_seq_exec_if #(.WIDTH(W)) bus2 ();

   mips_alu_seq_exec #(.WIDTH(W), .SHIFT_STEP(1)) u_step1 (.clk(clk), .rst(rst), .io_bus(bus1));
   mips_alu_seq_exec #(.WIDTH(W), .SHIFT_STEP(2)) u_step2 (.clk(clk), .rst(rst), .io_bus(bus2));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [SH_W-1:0] sh, input logic [W-1:0] a, input logic [W-1:0] b);
      bus1.in_valid = v; bus1.ALU_Op = op; bus1.funct = f; bus1.shamt = sh; bus1.A = a; bus1.B = b;
      bus2.in_valid = v; bus2.ALU_Op = op; bus2.funct = f; bus2.shamt = sh; bus2.A = a; bus2.B = b;
   endtask

   task automatic set_ready(input logic r);
      bus1.out_ready = r;
      bus2.out_ready = r;
   endtask

   // Reference: what the operation means arithmetically, plus its expected latency
   function automatic void model(input logic [1:0] op, input logic [5:0] f, input logic [SH_W-1:0] sh,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input int step,
                                 output logic [W-1:0] res, output logic ovf, output logic err,
                                 output int lat);
      longint s;
      int n;
      logic signed [W-1:0] sa;
      logic [SH_W-1:0] bamt;
      res = '0; ovf = 1'b0; err = 1'b0; lat = 1;
      bamt = b[SH_W-1:0];
      sa = a;
      if (op == 2'd0 || op == 2'd1 || (op == 2'd2 && (f == 6'h20 || f == 6'h22))) begin
         if (op == 2'd1 || f == 6'h22 && op == 2'd2) s = longint'(sa) - longint'($signed(b));
         else                                         s = longint'(sa) + longint'($signed(b));
         res = s[W-1:0];
         ovf = (s > MAX_S) || (s < MIN_S);
      end else if (op == 2'd2 && (f == 6'h00 || f == 6'h02 || f == 6'h03 ||
                                  f == 6'h04 || f == 6'h06 || f == 6'h07)) begin
         n = f[2] ? int'(bamt) : int'(sh);
         case (f[1:0])
            2'b00:   res = a << n;
            2'b10:   res = a >> n;
            default: res = sa >>> n;
         endcase
         lat = (n == 0) ? 1 : (n + step - 1) / step + 1;
      end else begin
         err = 1'b1;
      end
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [5:0] f, input logic [SH_W-1:0] sh,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit noise);
      logic [W-1:0] er;
      logic eo, ee;
      int el1, el2, lat1, lat2, cnt;
      model(op, f, sh, a, b, 1, er, eo, ee, el1);
      model(op, f, sh, a, b, 2, er, eo, ee, el2);
      chk("in_ready_before", 32'({bus1.in_ready, bus2.in_ready}), 32'h3);
      drive(1'b1, op, f, sh, a, b);
      @(posedge clk); #1;
      drive(noise, 2'($urandom), 6'($urandom), SH_W'($urandom), $urandom, $urandom);
      cnt = 1; lat1 = 0; lat2 = 0;
      forever begin
         if (bus1.out_valid && lat1 == 0) lat1 = cnt;
         if (bus2.out_valid && lat2 == 0) lat2 = cnt;
         if ((lat1 != 0 && lat2 != 0) || cnt >= 80) break;
         @(posedge clk); #1;
         cnt++;
      end
      chk("latency_step1", 32'(lat1), 32'(el1));
      chk("latency_step2", 32'(lat2), 32'(el2));
      chk("result_step1", bus1.result, er);
      chk("result_step2", bus2.result, er);
      chk("flags_step1", 32'({bus1.ovf, bus1.err}), 32'({eo, ee}));
      chk("flags_step2", 32'({bus2.ovf, bus2.err}), 32'({eo, ee}));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'({bus1.out_valid, bus2.out_valid, bus1.in_ready, bus2.in_ready}), 32'hC);
         chk("hold_result", bus1.result, er);
         chk("hold_flags", 32'({bus2.ovf, bus2.err}), 32'({eo, ee}));
      end
      drive(1'b0, 2'($urandom), 6'($urandom), SH_W'($urandom), $urandom, $urandom);
      set_ready(1'b1);
      @(posedge clk); #1;
      set_ready(1'b0);
      chk("after_handshake", 32'({bus1.out_valid, bus2.out_valid, bus1.in_ready, bus2.in_ready}), 32'h3);
      chk("idle_keeps_result", bus1.result, er);
   endtask

   task automatic reset_mid_shift();
      bit seen;
      drive(1'b1, 2'd2, 6'h02, SH_W'(20), 32'hDEAD_BEEF, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 2'd0, 6'h0, '0, '0, '0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_shift_out", 32'({bus1.out_valid, bus2.out_valid, bus1.in_ready, bus2.in_ready}), 32'h0);
      chk("rst_mid_shift_res", bus1.result | bus2.result, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("rst_release_ready", 32'({bus1.in_ready, bus2.in_ready, bus1.out_valid}), 32'h6);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus1.out_valid || bus2.out_valid) seen = 1'b1;
      end
      chk("no_stale_result", 32'(seen), 32'h0);
   endtask

   initial begin
      logic [5:0] legal [8] = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      logic [W-1:0] corner [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF000_0000};
      drive(1'b0, 2'd0, 6'h0, '0, '0, '0);
      set_ready(1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({bus1.out_valid, bus1.ovf, bus1.err, bus1.in_ready,
                               bus2.out_valid, bus2.ovf, bus2.err, bus2.in_ready}), 32'h0);
      chk("reset_result", bus1.result | bus2.result, 32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'({bus1.in_ready, bus2.in_ready}), 32'h3);

      run_op(2'd2, 6'h20, '0, 32'd7, 32'd5, 0, 1'b0);
      run_op(2'd1, 6'h00, '0, 32'h8000_0000, 32'd1, 0, 1'b0);
      run_op(2'd0, 6'h00, '0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
      run_op(2'd2, 6'h07, '0, 32'hF000_0000, 32'd4, 0, 1'b1);
      run_op(2'd2, 6'h00, '0, 32'h1234, 32'h0, 0, 1'b0);
      run_op(2'd2, 6'h02, SH_W'(31), 32'h8000_0000, 32'h0, 0, 1'b1);
      run_op(2'd0, 6'h00, '0, 32'd100, 32'd23, 3, 1'b1);
      run_op(2'd2, 6'h2A, '0, 32'h5555, 32'h3, 1, 1'b0);
      run_op(2'd3, 6'h20, '0, 32'h5555, 32'h3, 0, 1'b0);
      reset_mid_shift();

      for (int t = 0; t < 200; t++) begin
         int r;
         logic [1:0] op;
         logic [5:0] f;
         logic [W-1:0] a, b;
         r  = int'($urandom_range(0, 9));
         op = (r < 2) ? 2'(r) : (r < 9) ? 2'd2 : 2'd3;
         f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 7)];
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         run_op(op, f, SH_W'($urandom), a, b, int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
